store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 14 +
 rtl/sb_match.sv | 36 +++
 rtl/store_buffer.sv | 113 +++++++++++
 tb/tb_store_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: default geometry, the
// write-back stall code, and the layout of one buffered store.
package sb_pkg;

    localparam int         SB_DEPTH    = 4;
    localparam int         SB_PTR_W    = 2;
    localparam logic [2:0] SB_STALL_WB = 3'd6;

    typedef struct packed {
        logic [15:1] addr;
        logic [15:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the buffered stores: walks the FIFO from the
// oldest valid entry to the youngest so that later hits override earlier ones.
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0] rd_ptr_i,
    input  logic [PTR_W:0]   count_i,
    input  sb_entry_t        entries_i [DEPTH],
    input  logic [15:1]      addr_i,
    output logic             hit_o,
    output logic [15:0]      data_o
);

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] off;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        off    = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx = rd_ptr_i + PTR_W'(j);
            // Validity uses the wrapped distance from the read pointer.
            off = idx - rd_ptr_i;
            if (({1'b0, off} < count_i) && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: queues committed stores, drains them to memory in
// order, and forwards buffered data to loads with the same latency as memory.
module store_buffer
    import sb_pkg::*;
#(
    parameter int         DEPTH       = SB_DEPTH,
    parameter logic [2:0] STALL_STAGE = SB_STALL_WB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_wen,
    input  logic [15:1] core_waddr,
    input  logic [15:0] core_wdata,
    input  logic [15:1] core_raddr1,
    output logic [15:0] core_rdata1,
    output logic [2:0]  stall_num,
    output logic [15:1] mem_raddr1,
    input  logic [15:0] mem_rdata1,
    output logic        mem_wen,
    output logic [15:1] mem_waddr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             hit_q, hit_d;
    logic [15:0]      fwd_q, fwd_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             buf_hit;
    logic [15:0]      buf_data;

    assign full = (count_q == (PTR_W+1)'(DEPTH));
    // A stalled store is dropped outright; the core re-presents it.
    assign push = core_wen && !full;
    assign pop  = mem_wen && mem_ready;

    assign stall_num   = (core_wen && full) ? STALL_STAGE : 3'd0;
    assign mem_wen     = (count_q != '0);
    assign mem_waddr   = entries_q[rd_ptr_q].addr;
    assign mem_wdata   = entries_q[rd_ptr_q].data;
    assign mem_raddr1  = core_raddr1;
    assign core_rdata1 = hit_q ? fwd_q : mem_rdata1;

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .rd_ptr_i  (rd_ptr_q),
        .count_i   (count_q),
        .entries_i (entries_q),
        .addr_i    (core_raddr1),
        .hit_o     (buf_hit),
        .data_o    (buf_data)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The entry popped this cycle still matches: its memory write lands after the read.
    always_comb begin
        hit_d = buf_hit;
        fwd_d = buf_data;
        if (push && (core_waddr == core_raddr1)) begin
            hit_d = 1'b1;
            fwd_d = core_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hit_q    <= 1'b0;
            fwd_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hit_q    <= hit_d;
            fwd_q    <= fwd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{addr: core_waddr, data: core_wdata};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, full stall, forwarding, bypass,
// pointer wrap under continuous traffic, and asynchronous reset mid-drain.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wen;
    logic [15:1] core_waddr;
    logic [15:0] core_wdata;
    logic [15:1] core_raddr1;
    logic [15:0] core_rdata1;
    logic [2:0]  stall_num;
    logic [15:1] mem_raddr1;
    logic [15:0] mem_rdata1;
    logic        mem_wen;
    logic [15:1] mem_waddr;
    logic [15:0] mem_wdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [30:0] q[$];
    logic [15:1] pa;
    logic [15:0] pd;

    store_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .core_wen    (core_wen),
        .core_waddr  (core_waddr),
        .core_wdata  (core_wdata),
        .core_raddr1 (core_raddr1),
        .core_rdata1 (core_rdata1),
        .stall_num   (stall_num),
        .mem_raddr1  (mem_raddr1),
        .mem_rdata1  (mem_rdata1),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:1] a, input logic [15:0] d);
        core_wen   = 1'b1;
        core_waddr = a;
        core_wdata = d;
        tick();
        core_wen   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        core_wen    = 1'b0;
        core_waddr  = '0;
        core_wdata  = '0;
        core_raddr1 = '0;
        mem_rdata1  = 16'hA5A5;
        mem_ready   = 1'b0;
        repeat (2) tick();
        chk("rst_wen",   32'(mem_wen),     32'h0);
        chk("rst_stall", 32'(stall_num),   32'h0);
        chk("rst_rdata", 32'(core_rdata1), 32'hA5A5);
        chk("rst_cnt",   32'(dut.count_q), 32'h0);
        rst = 1'b0;

        // single store drains once memory is ready
        push(15'h0010, 16'hBEEF);
        chk("d1_wen",   32'(mem_wen),   32'h1);
        chk("d1_waddr", 32'(mem_waddr), 32'h0010);
        chk("d1_wdata", 32'(mem_wdata), 32'hBEEF);
        mem_ready = 1'b1;
        tick();
        chk("d1_cnt0", 32'(dut.count_q), 32'h0);
        chk("d1_wen0", 32'(mem_wen),     32'h0);
        mem_ready = 1'b0;

        // fill, stall on fifth store, retry after one drain
        for (int k = 1; k <= 4; k++) push(15'(k), 16'h1000 + 16'(k));
        core_wen   = 1'b1;
        core_waddr = 15'h0005;
        core_wdata = 16'h1005;
        #1;
        chk("f_stall", 32'(stall_num), 32'h6);
        tick();
        chk("f_cnt4",  32'(dut.count_q), 32'h4);
        chk("f_head1", 32'(mem_waddr),   32'h0001);
        mem_ready = 1'b1;
        tick();
        chk("f_cnt3a",  32'(dut.count_q), 32'h3);
        chk("f_head2",  32'(mem_waddr),   32'h0002);
        chk("f_nostl",  32'(stall_num),   32'h0);
        tick();
        core_wen = 1'b0;
        chk("f_cnt3b", 32'(dut.count_q), 32'h3);
        for (int e = 3; e <= 5; e++) begin
            chk("f_order_a", 32'(mem_waddr), 32'(e));
            chk("f_order_d", 32'(mem_wdata), 32'h1000 + 32'(e));
            tick();
        end
        chk("f_empty", 32'(dut.count_q), 32'h0);
        mem_ready = 1'b0;

        // youngest of two matching stores forwards
        push(15'h0020, 16'h1111);
        push(15'h0020, 16'h2222);
        core_raddr1 = 15'h0020;
        mem_rdata1  = 16'hFFFF;
        #1;
        chk("ld_raddr", 32'(mem_raddr1), 32'h0020);
        tick();
        chk("ld_young", 32'(core_rdata1), 32'h2222);
        core_raddr1 = 15'h0021;
        tick();
        chk("ld_miss", 32'(core_rdata1), 32'hFFFF);
        core_raddr1 = 15'h0020;
        mem_ready   = 1'b1;
        tick();
        chk("ld_pop_old", 32'(core_rdata1), 32'h2222);
        tick();
        chk("ld_pop_cur", 32'(core_rdata1), 32'h2222);
        tick();
        chk("ld_gone",  32'(core_rdata1), 32'hFFFF);
        chk("ld_cnt0",  32'(dut.count_q), 32'h0);
        mem_ready = 1'b0;

        // same-cycle bypass, then no bypass for a stalled store
        core_raddr1 = 15'h0030;
        push(15'h0030, 16'h4444);
        chk("byp_hit", 32'(core_rdata1), 32'h4444);
        core_raddr1 = 15'h0031;
        tick();
        chk("byp_miss", 32'(core_rdata1), 32'hFFFF);
        for (int k = 1; k <= 3; k++) push(15'h0040 + 15'(k), 16'h4040 + 16'(k));
        core_wen    = 1'b1;
        core_waddr  = 15'h0050;
        core_wdata  = 16'h5555;
        core_raddr1 = 15'h0050;
        tick();
        chk("byp_stalled", 32'(core_rdata1), 32'hFFFF);
        chk("byp_cnt4",    32'(dut.count_q), 32'h4);

        // continuous push and pop through pointer wrap
        q = '{ {15'h0030, 16'h4444}, {15'h0041, 16'h4041},
               {15'h0042, 16'h4042}, {15'h0043, 16'h4043} };
        pa = 15'h0050;
        pd = 16'h5555;
        core_raddr1 = 15'h0000;
        mem_ready   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            core_wen   = 1'b1;
            core_waddr = pa;
            core_wdata = pd;
            #1;
            chk("wr_wen",   32'(mem_wen),   32'h1);
            chk("wr_waddr", 32'(mem_waddr), 32'(q[0][30:16]));
            chk("wr_wdata", 32'(mem_wdata), 32'(q[0][15:0]));
            if (q.size() < 4) begin
                q.push_back({pa, pd});
                pa = (pa == 15'h0050) ? 15'h0060 : pa + 15'h0001;
                pd = 16'h6000 + 16'(pa);
            end
            void'(q.pop_front());
            tick();
        end
        core_wen = 1'b0;
        chk("wr_cnt", 32'(dut.count_q), 32'(q.size()));
        while (q.size() > 0) begin
            chk("wr_dr_addr", 32'(mem_waddr), 32'(q[0][30:16]));
            chk("wr_dr_data", 32'(mem_wdata), 32'(q[0][15:0]));
            void'(q.pop_front());
            tick();
        end
        chk("wr_empty", 32'(mem_wen), 32'h0);
        mem_ready = 1'b0;

        // asynchronous reset with three stores pending
        for (int k = 0; k < 3; k++) push(15'h0070 + 15'(k), 16'h7070 + 16'(k));
        chk("ar_cnt3", 32'(dut.count_q), 32'h3);
        core_raddr1 = 15'h0070;
        tick();
        chk("ar_hit", 32'(core_rdata1), 32'h7070);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_wen",   32'(mem_wen),     32'h0);
        chk("ar_cnt",   32'(dut.count_q), 32'h0);
        chk("ar_rdata", 32'(core_rdata1), 32'hFFFF);
        chk("ar_stall", 32'(stall_num),   32'h0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_nodrain", 32'(mem_wen), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
